// File: rtl/jtag_types_pkg.sv
// Shared JTAG/FIFO types and helpers.
// Holds the FIFO read-side state encoding and pointer arithmetic.
package jtag_types_pkg;

    typedef enum logic {
        RD_IDLE,
        RD_HOLD
    } fifo_rd_state_t;

    // Distance a - b of two binary pointers, modulo 2**w.
    // Shared with the write-side full logic.
    function automatic logic [31:0] ptr_diff(
        input logic [31:0] a,
        input logic [31:0] b,
        input int unsigned w
    );
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        return (a - b) & mask;
    endfunction

endpackage

// File: rtl/flex_fifo_rd_ctrl_if.sv
// Consumer-side valid/ready handshake of the FIFO read controller.
// master = FIFO output stage, slave = downstream consumer.
interface flex_fifo_rd_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic                  dout_ready;

    modport master (
        output dout,
        output dout_valid,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_valid,
        output dout_ready
    );
endinterface

// File: rtl/flex_fifo_rd_ctrl.sv
// Read-side controller for flex_fifo_mem: owns rptr and a registered
// first-word-fall-through output stage with valid/ready handshake.
module flex_fifo_rd_ctrl
    import jtag_types_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  rclk,
    input  logic                  n_rst,
    input  logic [ADDR_WIDTH:0]   wptr,
    input  logic                  flush,
    output logic [ADDR_WIDTH-1:0] raddr,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH:0]   rptr,
    output logic                  empty,
    output logic [ADDR_WIDTH+1:0] count,
    output logic                  ovf_err,
    flex_fifo_rd_ctrl_if.master   dout_if
);

    localparam logic [ADDR_WIDTH:0] DEPTH_P = {1'b1, {ADDR_WIDTH{1'b0}}};

    fifo_rd_state_t        state_q, state_d;
    logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  ovf_q, ovf_d;

    logic [ADDR_WIDTH:0]   mem_cnt;
    logic                  mem_empty;
    logic                  valid;
    logic                  pop;
    logic                  load;

    // Occupancy of the memory and the pop/load handshake decisions.
    always_comb begin
        mem_cnt   = (ADDR_WIDTH+1)'(ptr_diff(32'(wptr), 32'(rptr_q),
                                             ADDR_WIDTH + 1));
        mem_empty = (wptr == rptr_q);
        valid     = (state_q == RD_HOLD);
        pop       = dout_if.dout_ready & valid;
        load      = !mem_empty & (!valid | pop);
    end

    // State register: FSM state, read pointer, output stage, overflow flag.
    always_ff @(posedge rclk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= RD_IDLE;
            rptr_q  <= '0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rptr_q  <= rptr_d;
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic; flush wins over pop and load.
    always_comb begin
        state_d = state_q;
        rptr_d  = rptr_q;
        dout_d  = dout_q;
        ovf_d   = ovf_q | (mem_cnt > DEPTH_P);
        if (flush) begin
            rptr_d  = wptr;
            state_d = RD_IDLE;
        end else begin
            case (state_q)
                RD_IDLE: begin
                    if (load) begin
                        dout_d  = rdata;
                        rptr_d  = rptr_q + 1'b1;
                        state_d = RD_HOLD;
                    end
                end
                RD_HOLD: begin
                    if (pop && load) begin
                        dout_d = rdata;
                        rptr_d = rptr_q + 1'b1;
                    end else if (pop) begin
                        state_d = RD_IDLE;
                    end
                end
                default: state_d = RD_IDLE;
            endcase
        end
    end

    // Outputs are decoded from registers and wptr only.
    always_comb begin
        dout_if.dout       = dout_q;
        dout_if.dout_valid = valid;
        rptr               = rptr_q;
        raddr              = rptr_q[ADDR_WIDTH-1:0];
        ovf_err            = ovf_q;
        empty              = mem_empty & !valid;
        count              = (ADDR_WIDTH+2)'(mem_cnt)
                           + (ADDR_WIDTH+2)'(valid);
    end

endmodule

// File: tb/tb_flex_fifo_rd_ctrl.sv
// Directed self-checking bench for flex_fifo_rd_ctrl.
// Memory is modelled as a combinational array indexed by raddr.
module tb_flex_fifo_rd_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          rclk = 1'b0;
    logic          n_rst;
    logic [AW:0]   wptr;
    logic          flush;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;
    logic [AW:0]   rptr;
    logic          empty;
    logic [AW+1:0] count;
    logic          ovf_err;
    logic [DW-1:0] mem [16];

    int errors = 0;
    int checks = 0;

    flex_fifo_rd_ctrl_if #(.DATA_WIDTH(DW)) ifc ();

    flex_fifo_rd_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .rclk    (rclk),
        .n_rst   (n_rst),
        .wptr    (wptr),
        .flush   (flush),
        .raddr   (raddr),
        .rdata   (rdata),
        .rptr    (rptr),
        .empty   (empty),
        .count   (count),
        .ovf_err (ovf_err),
        .dout_if (ifc.master)
    );

    assign rdata = mem[raddr];

    always #5 rclk = ~rclk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] d);
        mem[wptr[AW-1:0]] = d;
        wptr = wptr + 1'b1;
    endtask

    task automatic do_reset();
        @(negedge rclk);
        n_rst = 1'b0;
        wptr = '0;
        flush = 1'b0;
        ifc.dout_ready = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        #1;
        chk("rst_valid", 32'(ifc.dout_valid), 0);
        chk("rst_rptr", 32'(rptr), 0);
        chk("rst_dout", 32'(ifc.dout), 0);
        chk("rst_ovf", 32'(ovf_err), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_count", 32'(count), 0);
        @(negedge rclk);
        n_rst = 1'b1;
    endtask

    initial begin
        n_rst = 1'b0;
        wptr = '0;
        flush = 1'b0;
        ifc.dout_ready = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = '0;

        // 1: reset then idle
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge rclk);
            chk("idle_empty", 32'(empty), 1);
            chk("idle_valid", 32'(ifc.dout_valid), 0);
            chk("idle_count", 32'(count), 0);
            chk("idle_raddr", 32'(raddr), 0);
        end

        // 2: fall-through under stall
        push(8'hA5);
        #1;
        chk("ft_count_pre", 32'(count), 1);
        chk("ft_valid_pre", 32'(ifc.dout_valid), 0);
        @(negedge rclk);
        chk("ft_valid", 32'(ifc.dout_valid), 1);
        chk("ft_dout", 32'(ifc.dout), 32'hA5);
        chk("ft_rptr", 32'(rptr), 1);
        chk("ft_count", 32'(count), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge rclk);
            chk("ft_hold_dout", 32'(ifc.dout), 32'hA5);
            chk("ft_hold_valid", 32'(ifc.dout_valid), 1);
        end
        // asynchronous reset mid-transfer
        #2;
        n_rst = 1'b0;
        #1;
        chk("async_valid", 32'(ifc.dout_valid), 0);
        chk("async_rptr", 32'(rptr), 0);

        // 3: streaming 16 words
        do_reset();
        ifc.dout_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            push(8'(i));
            @(negedge rclk);
            chk("stream_valid", 32'(ifc.dout_valid), 1);
            chk("stream_dout", 32'(ifc.dout), i);
        end
        @(negedge rclk);
        chk("stream_end_valid", 32'(ifc.dout_valid), 0);
        chk("stream_end_rptr", 32'(rptr), 32'h10);
        chk("stream_end_empty", 32'(empty), 1);

        // 4: full + 1 then overflow
        do_reset();
        for (int i = 0; i < 17; i++) begin
            push(8'(8'h40 + i));
            @(negedge rclk);
        end
        chk("full_count", 32'(count), 17);
        chk("full_ovf", 32'(ovf_err), 0);
        chk("full_dout", 32'(ifc.dout), 32'h40);
        push(8'h51);
        @(negedge rclk);
        chk("ovf_set", 32'(ovf_err), 1);
        ifc.dout_ready = 1'b1;
        repeat (3) @(negedge rclk);
        chk("ovf_sticky", 32'(ovf_err), 1);
        flush = 1'b1;
        @(negedge rclk);
        flush = 1'b0;
        chk("ovf_after_flush", 32'(ovf_err), 1);
        chk("flush_rptr", 32'(rptr), 32'(wptr));

        // 5: wrap-around from pointer 14
        do_reset();
        wptr = 5'd14;
        flush = 1'b1;
        @(negedge rclk);
        flush = 1'b0;
        chk("wrap_start_rptr", 32'(rptr), 14);
        chk("wrap_start_empty", 32'(empty), 1);
        ifc.dout_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push(8'(8'h30 + i));
            #1;
            chk("wrap_raddr", 32'(raddr), (14 + i) % 16);
            @(negedge rclk);
            chk("wrap_dout", 32'(ifc.dout), 32'h30 + i);
        end
        @(negedge rclk);
        chk("wrap_end_rptr", 32'(rptr), 20);
        chk("wrap_end_valid", 32'(ifc.dout_valid), 0);

        // 6: flush under stall with ready high
        do_reset();
        push(8'h50);
        @(negedge rclk);
        push(8'h51);
        @(negedge rclk);
        push(8'h52);
        @(negedge rclk);
        chk("fl_pre_valid", 32'(ifc.dout_valid), 1);
        chk("fl_pre_dout", 32'(ifc.dout), 32'h50);
        chk("fl_pre_count", 32'(count), 3);
        flush = 1'b1;
        ifc.dout_ready = 1'b1;
        @(negedge rclk);
        flush = 1'b0;
        chk("fl_valid", 32'(ifc.dout_valid), 0);
        chk("fl_rptr", 32'(rptr), 3);
        chk("fl_count", 32'(count), 0);
        chk("fl_empty", 32'(empty), 1);
        @(negedge rclk);
        chk("fl_post_valid", 32'(ifc.dout_valid), 0);
        chk("fl_post_rptr", 32'(rptr), 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
